// File: rtl/wb_regfile_hilo.sv
// wb_regfile_hilo: register file of the 5-stage MIPS pipeline.
// Commits the WB-stage write bus into 32 GPRs and the HI/LO registers, serves
// two combinational GPR read ports plus HI/LO to ID, and counts GPR writes.
// Optional build macro RF_BYPASS_EN: write-through bypass from the WB bus to
// the read outputs in the same cycle; undefined, reads return stored values.

// One GPR read port: $0 reads zero, optional same-cycle bypass from WB.
module wb_rf_rdport (
    input  logic [31:0][31:0] rf_q,
    input  logic [4:0]        raddr,
    input  logic              byp_vld,
    input  logic [4:0]        byp_addr,
    input  logic [31:0]       byp_data,
    output logic [31:0]       rdata
);

    // Read mux: zero register first, then bypass hit, else stored value
    always_comb begin
        rdata = rf_q[raddr];
        if (raddr == 5'd0)
            rdata = '0;
        else if (byp_vld && (byp_addr == raddr))
            rdata = byp_data;
    end

endmodule

module wb_regfile_hilo #(
    parameter int WB_TO_RF_WD = 104,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [WB_TO_RF_WD-1:0] wb_to_rf_bus,
    input  logic [4:0]             raddr1,
    output logic [31:0]            rdata1,
    input  logic [4:0]             raddr2,
    output logic [31:0]            rdata2,
    output logic [31:0]            hi_o,
    output logic [31:0]            lo_o,
    output logic [CNT_W-1:0]       wr_cnt
);

    localparam int NUM_RD = 2;

    // WB bus layout, MSB first
    typedef struct packed {
        logic        hi_we;
        logic [31:0] hi_wdata;
        logic        lo_we;
        logic [31:0] lo_wdata;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } wb_req_t;

    wb_req_t                      req;
    logic [31:0][31:0]            rf_q;
    logic [31:0]                  hi_q;
    logic [31:0]                  lo_q;
    logic [CNT_W-1:0]             cnt_q;
    logic                         gpr_we;
    logic                         byp_vld;
    logic [NUM_RD-1:0][4:0]       raddr_l;
    logic [NUM_RD-1:0][31:0]      rdata_l;

    assign req    = wb_req_t'(wb_to_rf_bus);
    // Writes to $0 are dropped and never counted
    assign gpr_we = req.rf_we && (req.rf_waddr != 5'd0);

    // GPR array; entry 0 is never written so it stays zero
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            rf_q <= '0;
        else if (gpr_we)
            rf_q[req.rf_waddr] <= req.rf_wdata;
    end

    // HI/LO commit independently; data bits are only sampled under their enable
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (req.hi_we) hi_q <= req.hi_wdata;
            if (req.lo_we) lo_q <= req.lo_wdata;
        end
    end

    // Committed GPR write counter, wraps naturally
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cnt_q <= '0;
        else if (gpr_we)
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign wr_cnt = cnt_q;

`ifdef RF_BYPASS_EN
    // Bypass is gated by resetn so all outputs read zero during reset
    assign byp_vld = resetn && gpr_we;
    assign hi_o    = (resetn && req.hi_we) ? req.hi_wdata : hi_q;
    assign lo_o    = (resetn && req.lo_we) ? req.lo_wdata : lo_q;
`else
    assign byp_vld = 1'b0;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
`endif

    assign raddr_l = {raddr2, raddr1};

    generate
        for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
            wb_rf_rdport u_rdport (
                .rf_q     (rf_q),
                .raddr    (raddr_l[g]),
                .byp_vld  (byp_vld),
                .byp_addr (req.rf_waddr),
                .byp_data (req.rf_wdata),
                .rdata    (rdata_l[g])
            );
        end
    endgenerate

    assign rdata1 = rdata_l[0];
    assign rdata2 = rdata_l[1];

endmodule

// File: tb/tb_wb_regfile_hilo.sv
// Bench for wb_regfile_hilo: directed steps, expected values queued from a
// reference model and popped at each sample point. A second instance with a
// 3-bit counter exercises counter wrap-around.
module tb_wb_regfile_hilo;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [103:0] bus = '0;
    logic [4:0]   raddr1 = '0;
    logic [4:0]   raddr2 = '0;
    logic [31:0]  rdata1, rdata2, hi_o, lo_o, wr_cnt;
    logic [31:0]  rd1_s, rd2_s, hi_s, lo_s;
    logic [2:0]   wr_cnt_s;

    int nvec  = 0;
    int nfail = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    logic [31:0] gpr_m [32];
    logic [31:0] hi_m, lo_m, cnt_m;

    always #5 clk = ~clk;

    wb_regfile_hilo #(.WB_TO_RF_WD(104), .CNT_W(32)) dut (
        .clk(clk), .resetn(resetn), .wb_to_rf_bus(bus),
        .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2),
        .hi_o(hi_o), .lo_o(lo_o), .wr_cnt(wr_cnt)
    );

    wb_regfile_hilo #(.WB_TO_RF_WD(104), .CNT_W(3)) dut_s (
        .clk(clk), .resetn(resetn), .wb_to_rf_bus(bus),
        .raddr1(raddr1), .rdata1(rd1_s), .raddr2(raddr2), .rdata2(rd2_s),
        .hi_o(hi_s), .lo_o(lo_s), .wr_cnt(wr_cnt_s)
    );

    function automatic logic [103:0] mk(input logic hwe, input logic [31:0] hd,
                                        input logic lwe, input logic [31:0] ld,
                                        input logic rwe, input logic [4:0] wa,
                                        input logic [31:0] wd);
        return {hwe, hd, lwe, ld, rwe, wa, wd};
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input logic [103:0] b);
        if (a == 5'd0) return 32'h0;
`ifdef RF_BYPASS_EN
        if (b[37] && b[36:32] != 5'd0 && b[36:32] == a) return b[31:0];
`endif
        return gpr_m[a];
    endfunction

    function automatic logic [31:0] exp_hi(input logic [103:0] b);
`ifdef RF_BYPASS_EN
        if (b[103]) return b[102:71];
`endif
        return hi_m;
    endfunction

    function automatic logic [31:0] exp_lo(input logic [103:0] b);
`ifdef RF_BYPASS_EN
        if (b[70]) return b[69:38];
`endif
        return lo_m;
    endfunction

    task automatic push(input string t, input logic [31:0] v);
        exp_t e;
        e.tag = t;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        nvec++;
        if (sb.size() == 0) begin
            nfail++;
            $error("FAIL scoreboard_empty: got %h want <queued value>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                nfail++;
                $error("FAIL %s: got %h want %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic clr_model();
        for (int i = 0; i < 32; i++) gpr_m[i] = '0;
        hi_m  = '0;
        lo_m  = '0;
        cnt_m = '0;
    endtask

    task automatic commit(input logic [103:0] b);
        if (b[37] && b[36:32] != 5'd0) begin
            gpr_m[b[36:32]] = b[31:0];
            cnt_m = cnt_m + 32'd1;
        end
        if (b[103]) hi_m = b[102:71];
        if (b[70])  lo_m = b[69:38];
    endtask

    // Drive one bus word for one cycle; check same-cycle and post-edge views
    task automatic step(input string tag, input logic [103:0] b,
                        input logic [4:0] a1, input logic [4:0] a2);
        bus = b; raddr1 = a1; raddr2 = a2;
        #1;
        push({tag, " rd1_now"}, exp_rd(a1, b));
        push({tag, " rd2_now"}, exp_rd(a2, b));
        push({tag, " hi_now"},  exp_hi(b));
        push({tag, " lo_now"},  exp_lo(b));
        chk(rdata1); chk(rdata2); chk(hi_o); chk(lo_o);
        @(posedge clk);
        commit(b);
        @(negedge clk);
        push({tag, " rd1_next"}, exp_rd(a1, b));
        push({tag, " rd2_next"}, exp_rd(a2, b));
        push({tag, " hi_next"},  exp_hi(b));
        push({tag, " lo_next"},  exp_lo(b));
        push({tag, " cnt"},      cnt_m);
        push({tag, " cnt3"},     {29'b0, cnt_m[2:0]});
        push({tag, " rd1_s"},    exp_rd(a1, b));
        chk(rdata1); chk(rdata2); chk(hi_o); chk(lo_o); chk(wr_cnt);
        chk({29'b0, wr_cnt_s}); chk(rd1_s);
    endtask

    initial begin
        clr_model();
        raddr1 = 5'd5;
        #2;
        push("rst rd1", 32'h0); push("rst hi", 32'h0);
        push("rst lo", 32'h0);  push("rst cnt", 32'h0);
        chk(rdata1); chk(hi_o); chk(lo_o); chk(wr_cnt);
        @(negedge clk);
        resetn = 1'b1;

        step("preload", mk(1'b1, 32'hAAAA0000, 1'b1, 32'h00005555, 1'b1, 5'd5, 32'h1234), 5'd5, 5'd5);

        // Reset mid-cycle while a write is pending on the bus
        bus = mk(1'b1, 32'h1, 1'b1, 32'h2, 1'b1, 5'd6, 32'h77);
        raddr1 = 5'd5; raddr2 = 5'd6;
        #2;
        resetn = 1'b0;
        clr_model();
        #1;
        push("midrst rd1", 32'h0); push("midrst hi", 32'h0);
        push("midrst lo", 32'h0);  push("midrst cnt", 32'h0);
        push("midrst cnt3", 32'h0);
        chk(rdata1); chk(hi_o); chk(lo_o); chk(wr_cnt); chk({29'b0, wr_cnt_s});
        @(posedge clk);
        @(negedge clk);
        push("inrst rd2", 32'h0); push("inrst rd1", 32'h0);
        push("inrst hi", 32'h0);  push("inrst cnt", 32'h0);
        chk(rdata2); chk(rdata1); chk(hi_o); chk(wr_cnt);
        bus = '0;
        resetn = 1'b1;

        step("basic",  mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 5'd7, 32'hDEADBEEF), 5'd7, 5'd7);
        step("zero",   mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF), 5'd0, 5'd7);
        step("hilo",   mk(1'b1, 32'h11111111, 1'b1, 32'h22222222, 1'b1, 5'd3, 32'h33), 5'd3, 5'd7);
        step("xbits",  mk(1'b0, 32'hx, 1'b0, 32'hx, 1'b0, 5'd9, 32'hx), 5'd3, 5'd9);
        step("pre9",   mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 5'd9, 32'hA), 5'd9, 5'd3);
        step("byp9",   mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 5'd9, 32'hB), 5'd9, 5'd3);
        step("idle",   '0, 5'd9, 5'd7);
        step("hionly", mk(1'b1, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0), 5'd9, 5'd3);
        step("loonly", mk(1'b0, 32'h0, 1'b1, 32'hBEEF0001, 1'b0, 5'd0, 32'h0), 5'd9, 5'd3);

        // Enough $4 commits to carry the 3-bit counter past all-ones
        for (int i = 0; i < 10; i++)
            step("wrap4", mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 5'd4, $urandom()), 5'd4, 5'($urandom_range(0, 31)));

        for (int i = 0; i < 12; i++)
            step("rand", mk(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)), $urandom(),
                            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom()),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

        if (sb.size() != 0) begin
            nvec++;
            nfail++;
            $error("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/wb_regfile_hilo.md
Name: wb_regfile_hilo

Overview:
- Consumer end of the writeback-to-register-file bus in the 5-stage MIPS pipeline.
- Holds 32 GPRs plus the HI/LO registers and commits the writes carried on the WB-stage bus.
- Serves two combinational GPR read ports and the HI/LO read values to ID.
- Keeps a committed-GPR-write counter for performance and debug.

Parameters:
- WB_TO_RF_WD, 104: width of the incoming WB bus; fixed packing below.
- CNT_W, 32: width of the write counter.

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- resetn  input  1  asynchronous, active-low reset.
- wb_to_rf_bus  input  WB_TO_RF_WD  packed write request, MSB->LSB:
  - hi_we [103]
  - hi_wdata [102:71]
  - lo_we [70]
  - lo_wdata [69:38]
  - rf_we [37]
  - rf_waddr [36:32]
  - rf_wdata [31:0]
- raddr1  input  5  GPR read address, port 1.
- rdata1  output  32  GPR read data, port 1.
- raddr2  input  5  GPR read address, port 2.
- rdata2  output  32  GPR read data, port 2.
- hi_o  output  32  current HI value.
- lo_o  output  32  current LO value.
- wr_cnt  output  CNT_W  count of committed GPR writes.

Behaviour:
- Reset:
  - resetn low clears all GPRs, HI, LO and wr_cnt to 0 immediately, without waiting for clk.
  - While resetn is low, every output reads 0 and all write requests are ignored.
  - First write accepted is at the first posedge with resetn high.
  - Reset asserted mid-stream: pending writes are lost; no partial update.
- GPR write:
  - At posedge, if rf_we=1 and rf_waddr!=0, GPR[rf_waddr] <= rf_wdata.
  - rf_waddr=0 is discarded; GPR0 always reads 0.
- HI/LO write:
  - At posedge, hi_we=1 loads hi_wdata; lo_we=1 loads lo_wdata.
  - The two are independent. Both in one cycle is legal and both commit. A GPR write in the same cycle also commits (mult/div + mfhi style overlap).
- Reads:
  - Purely combinational from the register array.
  - raddr=0 returns 0.
  - Both ports may address the same register; both return the identical value.
- Write latency:
  - A committed value is visible on rdata*/hi_o/lo_o in the cycle after the write posedge.
  - Same-cycle visibility is controlled by the optional feature below.
- Counter:
  - wr_cnt increments by 1 at each posedge that commits a GPR write (rf_we=1, rf_waddr!=0).
  - Wraps from all-ones to 0.
  - HI/LO-only writes and writes to $0 do not count.
- No stall input: WB already zeroes its bus on a bubble, so an all-zero bus is a no-op.
- Bits of the bus that are X while their we=0 must not propagate into state.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined, write-through bypass:
  - If rf_we=1, rf_waddr!=0 and raddrN==rf_waddr, rdataN = rf_wdata combinationally in the same cycle.
  - If hi_we=1, hi_o = hi_wdata; likewise lo_we -> lo_o = lo_wdata.
  - rf_waddr=0 is never bypassed.
  - Removes the WB->ID hazard, so ID no longer needs the separate wb_to_id forwarding path.
- Undefined: reads return stored values only; new data appears the cycle after the write posedge.
- Stored state and wr_cnt are identical in both builds.

Test Plan:
- Reset: drive resetn=0 mid-cycle after preloading GPR5=0x1234 -> rdata1(raddr1=5)=0, hi_o=lo_o=0, wr_cnt=0 before the next clk edge.
- Basic write/read: rf_we=1, waddr=7, wdata=0xDEADBEEF for one cycle -> next cycle rdata1=rdata2=0xDEADBEEF with raddr1=raddr2=7, wr_cnt=1.
- $0 protection: rf_we=1, waddr=0, wdata=0xFFFFFFFF -> rdata1(raddr1=0)=0, wr_cnt unchanged.
- HI/LO plus GPR in one cycle: hi_we=1 hi=0x11111111, lo_we=1 lo=0x22222222, rf_we=1 waddr=3 wdata=0x33 -> next cycle hi_o=0x11111111, lo_o=0x22222222, GPR3=0x33, wr_cnt +1.
- Bypass: GPR9=0xA, then write 9<-0xB with raddr1=9:
  - RF_BYPASS_EN defined: rdata1=0xB in the same cycle.
  - Undefined: rdata1=0xA in that cycle, 0xB in the next.
- Counter wrap: force wr_cnt to 0xFFFFFFFF, then commit one write to $4 -> wr_cnt=0.
